uart_cmd_dispatcher: RTL and testbench
======================================

Name: uart_cmd_dispatcher

Overview:
Consumes complete received messages from the receive side of uart_process (the FIFO_Q / MSG_LEN / PARITY_OUT / GOT_FULL_MESSAGE interface). It drains and buffers each message, checks its parity and length, and then commits the payload as register writes. It then returns a one-word acknowledge message through the transmit side of uart_process (DATA / ENA / MSG_LEN_IN / PARITY_IN / BUSY). It sits between uart_process and the board's control-register bank.

Parameters:
MAX_PAYLOAD, 16, maximum payload words per message, excluding the header word; sets the buffer depth.
ACK_OK, 8'h00, status code for an accepted message.
ACK_PAR, 8'h01, status code for a parity error.
ACK_LEN, 8'h02, status code for a length error.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous reset, active-high.
GOT_FULL_MESSAGE  in  1  level; a complete message is waiting. MSG_LEN and PARITY_OUT are valid while this is high.
MSG_LEN  in  8  message length in 16-bit words, including the header.
PARITY_OUT  in  1  received parity: XOR-reduction of all bits of all message words.
FIFO_Q  in  16  receive FIFO read data; valid 1 cycle after RD_REQ.
RD_REQ  out  1  receive FIFO read strobe, one word per cycle.
MSG_START  out  1  1-cycle pulse marking the start of message consumption.
TX_DATA  out  16  ack word, to DATA.
TX_ENA  out  1  1-cycle send strobe, to ENA.
TX_MSG_LEN  out  8  ack length, to MSG_LEN_IN; always 1.
TX_PARITY  out  1  ack parity, to PARITY_IN.
TX_BUSY  in  1  from BUSY; the transmitter cannot accept a message.
REG_WR_EN  out  1  register write strobe.
REG_ADDR  out  8  register address.
REG_WDATA  out  16  register write data.
ERR_CNT  out  16  count of rejected messages; saturates at 16'hFFFF.

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- ERR_CNT is 0 and the buffer contents are don't-care.
- A reset asserted in any state aborts the transfer at once, with no further RD_REQ, REG_WR_EN or TX_ENA. A partly drained message is abandoned.

State IDLE:
- Sample GOT_FULL_MESSAGE. When it is high, latch MSG_LEN into len and PARITY_OUT into exp_par, then go to START.
- GOT_FULL_MESSAGE is ignored in every other state.

State START:
- MSG_START=1 for exactly this cycle. Clear the word counters and the running parity.
- If len==0: status=ACK_LEN, base=8'h00, go to ACK_WAIT with no reads.
- Otherwise go to READ.

State READ:
- RD_REQ=1 for exactly len consecutive cycles.
- Each FIFO_Q word is captured the cycle after its RD_REQ, so capture runs 1 cycle behind the requests.
- The running parity accumulates ^FIFO_Q for every word.
- Word 0 is the header: base address = FIFO_Q[15:8]; FIFO_Q[7:0] is reserved and ignored.
- Words 1..len-1 are written to buf[0..len-2] while the index is < MAX_PAYLOAD. Excess words are still read, so the FIFO always drains fully, but they are discarded.
- After the last capture, go to CHECK.

State CHECK (1 cycle), status priority:
- len-1 > MAX_PAYLOAD gives ACK_LEN.
- Otherwise running parity != exp_par gives ACK_PAR.
- Otherwise ACK_OK.
- ACK_OK with len==1 (header only) goes straight to ACK_WAIT. Other ACK_OK goes to COMMIT. Errors go to ACK_WAIT and increment ERR_CNT (saturating).

State COMMIT:
- One write per cycle for k=0..len-2: REG_WR_EN=1, REG_ADDR=base+k (8-bit wrap-around, e.g. base FF then 00), REG_WDATA=buf[k].
- Writes are registered outputs on back-to-back cycles. When they are done, go to ACK_WAIT.

State ACK_WAIT:
- Hold while TX_BUSY=1. When TX_BUSY=0, go to ACK.

State ACK (1 cycle):
- TX_ENA=1, TX_DATA={base, status}, TX_MSG_LEN=1, TX_PARITY=^TX_DATA. Then go to IDLE.
- TX_DATA, TX_MSG_LEN and TX_PARITY hold their values until the next ACK.

Other rules:
- No register write ever occurs for a rejected message.
- If TX_BUSY rises in the same cycle as the ACK state, the send still happens. uart_process samples ENA, so the transmitter is required to accept it; TX_BUSY is only checked in ACK_WAIT.
- Minimum IDLE-to-IDLE time for len=N, ACK_OK, TX_BUSY=0: 1 (START) + N + 1 (capture tail) + 1 (CHECK) + (N-1) + 1 (ACK_WAIT) + 1 (ACK).

Decomposition:
- Shared package/defines: state encoding, the ACK_* status codes and the ack-length constant 1. F_clk stays in defines.v.
- One natural sub-module: uart_cmd_buffer, a MAX_PAYLOAD x 16 simple dual-port RAM with registered read.
- Because the RAM read is registered, COMMIT pre-fetches one address ahead so that writes stay back-to-back.

Test Plan:
1. Header 16'h1000 plus payload 16'hAAAA, 16'h5555, len=3, correct parity -> 1 MSG_START, 3 RD_REQ; writes (10,AAAA), (11,5555); TX_DATA=16'h1000, TX_PARITY=1, TX_ENA once; ERR_CNT=0.
2. Same message with PARITY_OUT inverted -> 3 reads, no REG_WR_EN, TX_DATA=16'h1001, ERR_CNT=1.
3. len=MAX_PAYLOAD+2=18 -> 18 RD_REQ (FIFO fully drained), no writes, status 02, ERR_CNT increments.
4. Header 16'hFF00 plus 2 payload words -> REG_ADDR sequence FF then 00 (wrap-around); ack 16'hFF00.
5. TX_BUSY held high for 50 cycles at ack time -> TX_ENA is delayed until the cycle after TX_BUSY falls; GOT_FULL_MESSAGE toggled during that wait is ignored.
6. RST pulsed mid-READ (after 2 of 5 reads) -> next cycle RD_REQ=0 and all outputs 0; a new message afterwards is processed normally.

Source files
------------

// File: rtl/uart_cmd_dispatcher_pkg.sv
// Shared types and constants for the UART command dispatcher.
// Holds the FSM encoding, default ack status codes and the ack word layout.
package uart_cmd_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_READ     = 3'd2,
      ST_CHECK    = 3'd3,
      ST_COMMIT   = 3'd4,
      ST_ACK_WAIT = 3'd5,
      ST_ACK      = 3'd6
   } state_e;

   localparam int unsigned MAX_PAYLOAD_DEF = 16;

   localparam logic [7:0] ACK_OK_DEF  = 8'h00;
   localparam logic [7:0] ACK_PAR_DEF = 8'h01;
   localparam logic [7:0] ACK_LEN_DEF = 8'h02;

   // The acknowledge is always a single word
   localparam logic [7:0] ACK_MSG_LEN = 8'd1;

   typedef struct packed {
      logic [7:0] base;
      logic [7:0] status;
   } ack_word_t;

   function automatic logic word_parity(input logic [15:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_buffer.sv
// Payload buffer: simple dual-port RAM, one write port, one registered read port.
// Memory contents are not reset; only the read register clears.
module uart_cmd_buffer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Drains complete messages from uart_process, checks length and parity,
// commits the payload as register writes and returns a one-word ack.
module uart_cmd_dispatcher
   import uart_cmd_dispatcher_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF,
   parameter logic [7:0]  ACK_OK      = ACK_OK_DEF,
   parameter logic [7:0]  ACK_PAR     = ACK_PAR_DEF,
   parameter logic [7:0]  ACK_LEN     = ACK_LEN_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        GOT_FULL_MESSAGE,
   input  logic [7:0]  MSG_LEN,
   input  logic        PARITY_OUT,
   input  logic [15:0] FIFO_Q,
   output logic        RD_REQ,
   output logic        MSG_START,
   output logic [15:0] TX_DATA,
   output logic        TX_ENA,
   output logic [7:0]  TX_MSG_LEN,
   output logic        TX_PARITY,
   input  logic        TX_BUSY,
   output logic        REG_WR_EN,
   output logic [7:0]  REG_ADDR,
   output logic [15:0] REG_WDATA,
   output logic [15:0] ERR_CNT
);

   localparam int unsigned BUF_AW  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [8:0]  MAX_LEN = 9'(MAX_PAYLOAD + 1);
   localparam logic [8:0]  MAX_PL9 = 9'(MAX_PAYLOAD);

   state_e state_q, state_d;

   // Message context
   logic [7:0]  len_q, len_d;
   logic        exp_par_q, exp_par_d;
   logic [7:0]  base_q, base_d;
   logic [7:0]  status_q, status_d;
   logic        par_q, par_d;
   logic [8:0]  rd_cnt_q, rd_cnt_d;
   logic [7:0]  cmt_cnt_q, cmt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        err_inc;

   // Registered outputs
   logic        rd_req_q, rd_req_d;
   logic        msg_start_q, msg_start_d;
   logic [15:0] tx_data_q, tx_data_d;
   logic        tx_ena_q, tx_ena_d;
   logic [7:0]  tx_msg_len_q, tx_msg_len_d;
   logic        tx_parity_q, tx_parity_d;
   logic        reg_wr_en_q, reg_wr_en_d;
   logic [7:0]  reg_addr_q, reg_addr_d;

   // Buffer ports
   logic              buf_wr_en;
   logic [BUF_AW-1:0] buf_wr_addr;
   logic              buf_rd_en;
   logic [BUF_AW-1:0] buf_rd_addr;
   logic [15:0]       buf_rd_data;

   logic [7:0] chk_status;
   logic       commit_last;
   ack_word_t  ack_w;

   always_comb begin
      if ({1'b0, len_q} > MAX_LEN) begin
         chk_status = ACK_LEN;
      end else if (par_q != exp_par_q) begin
         chk_status = ACK_PAR;
      end else begin
         chk_status = ACK_OK;
      end
   end

   assign commit_last = (({1'b0, cmt_cnt_q} + 9'd2) == {1'b0, len_q});
   assign ack_w       = '{base: base_q, status: status_q};

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (GOT_FULL_MESSAGE) state_d = ST_START;
         ST_START:    state_d = (len_q == 8'd0) ? ST_ACK_WAIT : ST_READ;
         ST_READ:     if (rd_cnt_q == {1'b0, len_q}) state_d = ST_CHECK;
         ST_CHECK: begin
            if ((chk_status != ACK_OK) || (len_q == 8'd1)) begin
               state_d = ST_ACK_WAIT;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT:   if (commit_last) state_d = ST_ACK_WAIT;
         ST_ACK_WAIT: if (!TX_BUSY) state_d = ST_ACK;
         ST_ACK:      state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; read capture runs one cycle behind RD_REQ
   always_comb begin
      len_d       = len_q;
      exp_par_d   = exp_par_q;
      base_d      = base_q;
      status_d    = status_q;
      par_d       = par_q;
      rd_cnt_d    = '0;
      cmt_cnt_d   = '0;
      err_cnt_d   = err_cnt_q;
      err_inc     = 1'b0;
      buf_wr_en   = 1'b0;
      buf_wr_addr = '0;
      buf_rd_en   = 1'b0;
      buf_rd_addr = '0;

      case (state_q)
         ST_IDLE: begin
            if (GOT_FULL_MESSAGE) begin
               len_d     = MSG_LEN;
               exp_par_d = PARITY_OUT;
            end
         end
         ST_START: begin
            par_d = 1'b0;
            if (len_q == 8'd0) begin
               status_d = ACK_LEN;
               base_d   = 8'h00;
               err_inc  = 1'b1;
            end
         end
         ST_READ: begin
            rd_cnt_d = rd_cnt_q + 9'd1;
            if (rd_cnt_q != 9'd0) begin
               par_d = par_q ^ word_parity(FIFO_Q);
               if (rd_cnt_q == 9'd1) begin
                  base_d = FIFO_Q[15:8];
               end else if ((rd_cnt_q - 9'd2) < MAX_PL9) begin
                  buf_wr_en   = 1'b1;
                  buf_wr_addr = BUF_AW'(rd_cnt_q - 9'd2);
               end
            end
         end
         ST_CHECK: begin
            status_d  = chk_status;
            err_inc   = (chk_status != ACK_OK);
            buf_rd_en = 1'b1;
         end
         ST_COMMIT: begin
            // RAM read is registered, so fetch the word for the next write now
            cmt_cnt_d = cmt_cnt_q + 8'd1;
            if (!commit_last) begin
               buf_rd_en   = 1'b1;
               buf_rd_addr = BUF_AW'(cmt_cnt_q + 8'd1);
            end
         end
         default: ;
      endcase

      if (err_inc && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Registered output decode from the next state
   always_comb begin
      rd_req_d     = (state_d == ST_READ) && (rd_cnt_d < {1'b0, len_q});
      msg_start_d  = (state_d == ST_START);
      reg_wr_en_d  = (state_d == ST_COMMIT);
      reg_addr_d   = reg_addr_q;
      tx_ena_d     = (state_d == ST_ACK);
      tx_data_d    = tx_data_q;
      tx_msg_len_d = tx_msg_len_q;
      tx_parity_d  = tx_parity_q;

      if (reg_wr_en_d) begin
         reg_addr_d = base_q + cmt_cnt_d;
      end
      if (tx_ena_d) begin
         tx_data_d    = ack_w;
         tx_msg_len_d = ACK_MSG_LEN;
         tx_parity_d  = word_parity(ack_w);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         len_q        <= '0;
         exp_par_q    <= 1'b0;
         base_q       <= '0;
         status_q     <= '0;
         par_q        <= 1'b0;
         rd_cnt_q     <= '0;
         cmt_cnt_q    <= '0;
         err_cnt_q    <= '0;
         rd_req_q     <= 1'b0;
         msg_start_q  <= 1'b0;
         tx_data_q    <= '0;
         tx_ena_q     <= 1'b0;
         tx_msg_len_q <= '0;
         tx_parity_q  <= 1'b0;
         reg_wr_en_q  <= 1'b0;
         reg_addr_q   <= '0;
      end else begin
         len_q        <= len_d;
         exp_par_q    <= exp_par_d;
         base_q       <= base_d;
         status_q     <= status_d;
         par_q        <= par_d;
         rd_cnt_q     <= rd_cnt_d;
         cmt_cnt_q    <= cmt_cnt_d;
         err_cnt_q    <= err_cnt_d;
         rd_req_q     <= rd_req_d;
         msg_start_q  <= msg_start_d;
         tx_data_q    <= tx_data_d;
         tx_ena_q     <= tx_ena_d;
         tx_msg_len_q <= tx_msg_len_d;
         tx_parity_q  <= tx_parity_d;
         reg_wr_en_q  <= reg_wr_en_d;
         reg_addr_q   <= reg_addr_d;
      end
   end

   uart_cmd_buffer #(
      .DEPTH  (MAX_PAYLOAD),
      .WIDTH  (16),
      .ADDR_W (BUF_AW)
   ) u_buf (
      .clk_i     (CLK),
      .rst_i     (RST),
      .wr_en_i   (buf_wr_en),
      .wr_addr_i (buf_wr_addr),
      .wr_data_i (FIFO_Q),
      .rd_en_i   (buf_rd_en),
      .rd_addr_i (buf_rd_addr),
      .rd_data_o (buf_rd_data)
   );

   assign RD_REQ     = rd_req_q;
   assign MSG_START  = msg_start_q;
   assign TX_DATA    = tx_data_q;
   assign TX_ENA     = tx_ena_q;
   assign TX_MSG_LEN = tx_msg_len_q;
   assign TX_PARITY  = tx_parity_q;
   assign REG_WR_EN  = reg_wr_en_q;
   assign REG_ADDR   = reg_addr_q;
   assign REG_WDATA  = buf_rd_data;
   assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher: FIFO model, output monitor and
// hand-computed expectations for each message scenario.
module tb_uart_cmd_dispatcher;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        GOT_FULL_MESSAGE = 1'b0;
   logic [7:0]  MSG_LEN = '0;
   logic        PARITY_OUT = 1'b0;
   logic [15:0] FIFO_Q = '0;
   logic        TX_BUSY = 1'b0;
   logic        RD_REQ, MSG_START, TX_ENA, TX_PARITY, REG_WR_EN;
   logic [15:0] TX_DATA, REG_WDATA, ERR_CNT;
   logic [7:0]  TX_MSG_LEN, REG_ADDR;

   always #5 CLK = ~CLK;

   uart_cmd_dispatcher dut (
      .CLK              (CLK),
      .RST              (RST),
      .GOT_FULL_MESSAGE (GOT_FULL_MESSAGE),
      .MSG_LEN          (MSG_LEN),
      .PARITY_OUT       (PARITY_OUT),
      .FIFO_Q           (FIFO_Q),
      .RD_REQ           (RD_REQ),
      .MSG_START        (MSG_START),
      .TX_DATA          (TX_DATA),
      .TX_ENA           (TX_ENA),
      .TX_MSG_LEN       (TX_MSG_LEN),
      .TX_PARITY        (TX_PARITY),
      .TX_BUSY          (TX_BUSY),
      .REG_WR_EN        (REG_WR_EN),
      .REG_ADDR         (REG_ADDR),
      .REG_WDATA        (REG_WDATA),
      .ERR_CNT          (ERR_CNT)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Receive FIFO model: data appears the cycle after RD_REQ
   logic [15:0] fifo_mem [0:1023];
   logic [9:0]  wr_ptr = '0;
   logic [9:0]  rd_ptr = '0;

   always @(posedge CLK) begin
      if (RD_REQ === 1'b1) begin
         FIFO_Q <= fifo_mem[rd_ptr];
         rd_ptr <= rd_ptr + 10'd1;
      end
   end

   // Output monitor, sampled on the falling edge
   int cyc = 0, rd_cnt = 0, ms_cnt = 0, ena_cnt = 0, ms_cyc = 0, ena_cyc = 0, wr_cnt = 0;
   logic [23:0] wr_log [0:255];

   always @(negedge CLK) begin
      if (RD_REQ === 1'b1) rd_cnt++;
      if (MSG_START === 1'b1) begin ms_cnt++; ms_cyc = cyc; end
      if (TX_ENA === 1'b1) begin ena_cnt++; ena_cyc = cyc; end
      if (REG_WR_EN === 1'b1) begin
         wr_log[wr_cnt[7:0]] = {REG_ADDR, REG_WDATA};
         wr_cnt++;
      end
      cyc++;
   end

   int rd0, wr0, e0, ms0, drop_cyc;
   logic msg_par;
   logic [23:0] exp_wr [0:7];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic snap();
      rd0 = rd_cnt; wr0 = wr_cnt; e0 = ena_cnt; ms0 = ms_cnt; msg_par = 1'b0;
   endtask

   task automatic push(input logic [15:0] w);
      fifo_mem[wr_ptr] = w;
      wr_ptr  = wr_ptr + 10'd1;
      msg_par = msg_par ^ (^w);
   endtask

   task automatic launch(input logic [7:0] len, input logic par);
      MSG_LEN = len; PARITY_OUT = par; GOT_FULL_MESSAGE = 1'b1;
      for (int i = 0; i < 20 && ms_cnt == ms0; i++) tick();
      GOT_FULL_MESSAGE = 1'b0;
      check("msg_start_once", 32'(ms_cnt - ms0), 32'd1);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 400 && ena_cnt == e0; i++) tick();
      tick(); tick();
      check("tx_ena_once", 32'(ena_cnt - e0), 32'd1);
   endtask

   task automatic check_writes(input int n);
      check("wr_count", 32'(wr_cnt - wr0), 32'(n));
      for (int i = 0; i < n && i < (wr_cnt - wr0); i++)
         check($sformatf("wr%0d", i), 32'(wr_log[8'(wr0 + i)]), 32'(exp_wr[i]));
   endtask

   task automatic check_ack(input logic [15:0] data, input logic par);
      check("tx_data", 32'(TX_DATA), 32'(data));
      check("tx_parity", 32'(TX_PARITY), 32'(par));
      check("tx_msg_len", 32'(TX_MSG_LEN), 32'd1);
   endtask

   initial begin
      tick(); tick(); tick();
      check("rst_rd_req", 32'(RD_REQ), 32'd0);
      check("rst_outs", 32'({MSG_START, TX_ENA, REG_WR_EN, TX_PARITY}), 32'd0);
      check("rst_tx_data", 32'(TX_DATA), 32'd0);
      check("rst_err_cnt", 32'(ERR_CNT), 32'd0);
      RST = 1'b0;
      tick();

      // 1: good message, two writes
      snap(); push(16'h1000); push(16'hAAAA); push(16'h5555);
      launch(8'd3, msg_par); wait_ack();
      check("t1_reads", 32'(rd_cnt - rd0), 32'd3);
      exp_wr[0] = 24'h10AAAA; exp_wr[1] = 24'h115555; check_writes(2);
      check_ack(16'h1000, 1'b1);
      check("t1_err", 32'(ERR_CNT), 32'd0);
      check("t1_latency", 32'(ena_cyc - ms_cyc), 32'd9);

      // 2: parity error
      snap(); push(16'h1000); push(16'hAAAA); push(16'h5555);
      launch(8'd3, ~msg_par); wait_ack();
      check("t2_reads", 32'(rd_cnt - rd0), 32'd3);
      check_writes(0);
      check_ack(16'h1001, 1'b0);
      check("t2_err", 32'(ERR_CNT), 32'd1);

      // 3: too long, with bad parity too; length wins
      snap(); push(16'h2000);
      for (int i = 0; i < 17; i++) push(16'(i * 16'h0123 + 16'h0011));
      launch(8'd18, ~msg_par); wait_ack();
      check("t3_reads", 32'(rd_cnt - rd0), 32'd18);
      check("t3_drained", 32'(rd_ptr), 32'(wr_ptr));
      check_writes(0);
      check_ack(16'h2002, 1'b0);
      check("t3_err", 32'(ERR_CNT), 32'd2);

      // 4: address wrap
      snap(); push(16'hFF00); push(16'h1234); push(16'h5678);
      launch(8'd3, msg_par); wait_ack();
      exp_wr[0] = 24'hFF1234; exp_wr[1] = 24'h005678; check_writes(2);
      check_ack(16'hFF00, 1'b0);
      check("t4_err", 32'(ERR_CNT), 32'd2);

      // Header-only message
      snap(); push(16'h5500);
      launch(8'd1, msg_par); wait_ack();
      check("hdr_reads", 32'(rd_cnt - rd0), 32'd1);
      check_writes(0);
      check_ack(16'h5500, 1'b0);
      check("hdr_latency", 32'(ena_cyc - ms_cyc), 32'd5);

      // 5: transmitter busy at ack time, GOT_FULL_MESSAGE toggled meanwhile
      snap(); TX_BUSY = 1'b1; push(16'h3000); push(16'h00FF);
      launch(8'd2, msg_par);
      for (int i = 0; i < 50; i++) begin
         if (i == 10) begin MSG_LEN = 8'd3; PARITY_OUT = 1'b1; GOT_FULL_MESSAGE = 1'b1; end
         if (i == 20) GOT_FULL_MESSAGE = 1'b0;
         tick();
      end
      check("t5_no_ena_busy", 32'(ena_cnt - e0), 32'd0);
      check("t5_gfm_ignored", 32'(ms_cnt - ms0), 32'd1);
      check("t5_reads", 32'(rd_cnt - rd0), 32'd2);
      exp_wr[0] = 24'h3000FF; check_writes(1);
      TX_BUSY = 1'b0; drop_cyc = cyc;
      wait_ack();
      check("t5_release", 32'(ena_cyc - drop_cyc), 32'd1);
      check_ack(16'h3000, 1'b0);

      // 6: reset mid-read after two requests
      snap(); push(16'h6000); push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      launch(8'd5, msg_par);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); #1;
         if ((rd_cnt - rd0) >= 2) break;
      end
      RST = 1'b1;
      tick();
      check("t6_rd_req", 32'(RD_REQ), 32'd0);
      check("t6_outs", 32'({MSG_START, TX_ENA, REG_WR_EN, TX_PARITY}), 32'd0);
      check("t6_tx_data", 32'(TX_DATA), 32'd0);
      check("t6_addr_len", 32'({REG_ADDR, TX_MSG_LEN}), 32'd0);
      check("t6_err", 32'(ERR_CNT), 32'd0);
      RST = 1'b0; wr_ptr = rd_ptr;
      tick(); tick(); tick();
      check("t6_reads", 32'(rd_cnt - rd0), 32'd2);
      check_writes(0);

      snap(); push(16'h4000); push(16'h1234);
      launch(8'd2, msg_par); wait_ack();
      exp_wr[0] = 24'h401234; check_writes(1);
      check_ack(16'h4000, 1'b1);
      check("t6b_err", 32'(ERR_CNT), 32'd0);

      // Zero-length message: no reads, length error
      snap();
      launch(8'd0, 1'b0); wait_ack();
      check("len0_reads", 32'(rd_cnt - rd0), 32'd0);
      check_writes(0);
      check_ack(16'h0002, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
